// File: rtl/hamming_tx_ctrl.sv
// Transmit sequencer for the 12/8 Hamming encoder: accepts a byte, strobes the encoder,
// captures the codeword after ENC_LAT cycles and sends it as start + 12 bits LSB first + stop.
module hamming_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ENC_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        enc_wren,
  output logic [7:0]  enc_data,
  input  logic [11:0] enc_hc,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(ENC_LAT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [LW-1:0] LAT_LAST  = LW'(ENC_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WREN, S_WAIT, S_START, S_DATA, S_STOP} state_t;

  state_t          state_reg;
  logic [7:0]      data_q;
  logic [11:0]     shift_q;
  logic [BW-1:0]   baud_cnt;
  logic [LW-1:0]   lat_cnt;
  logic [3:0]      bit_idx;
  logic            s_ready_reg;
  logic            enc_wren_reg;
  logic            tx_reg;
  logic            frame_done_reg;

  // Outputs are loaded with the value they must show in the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      data_q         <= '0;
      shift_q        <= '0;
      baud_cnt       <= '0;
      lat_cnt        <= '0;
      bit_idx        <= '0;
      s_ready_reg    <= 1'b1;
      enc_wren_reg   <= 1'b0;
      tx_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      enc_wren_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (s_valid && s_ready_reg) begin
            data_q       <= s_data;
            state_reg    <= S_WREN;
            enc_wren_reg <= 1'b1;
            s_ready_reg  <= 1'b0;
          end
        end
        S_WREN: begin
          state_reg <= S_WAIT;
          lat_cnt   <= '0;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            shift_q   <= enc_hc;
            state_reg <= S_START;
            tx_reg    <= 1'b0;
            baud_cnt  <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_START: begin
          if (baud_cnt == BAUD_LAST) begin
            state_reg <= S_DATA;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_reg    <= shift_q[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            shift_q  <= shift_q >> 1;
            if (bit_idx == 4'd11) begin
              state_reg <= S_STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx_reg  <= shift_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            state_reg   <= S_IDLE;
            s_ready_reg <= 1'b1;
            baud_cnt    <= '0;
          end else begin
            baud_cnt       <= baud_cnt + 1'b1;
            // Raise one cycle early so the pulse lands in the final stop-bit cycle.
            frame_done_reg <= (baud_cnt == BAUD_PRE);
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          s_ready_reg <= 1'b1;
          tx_reg      <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready    = s_ready_reg;
  assign busy       = !s_ready_reg;
  assign enc_wren   = enc_wren_reg;
  assign enc_data   = data_q;
  assign tx         = tx_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// Randomized self-checking bench for hamming_tx_ctrl: the expected line waveform is derived
// from the frame format (start, 12 bits LSB first, stop) relative to the accept edge.
module tb_hamming_tx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_ready, enc_wren, tx, busy, frame_done;
  logic [7:0]  enc_data;
  logic [11:0] enc_hc = '0;

  logic        s_valid2 = 1'b0;
  logic [7:0]  s_data2 = '0;
  logic        s_ready2, enc_wren2, tx2, busy2, frame_done2;
  logic [7:0]  enc_data2;
  logic [11:0] enc_hc2 = '0;

  logic        fixed_en = 1'b0;
  logic [11:0] fixed_cw = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_tx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .enc_wren(enc_wren), .enc_data(enc_data), .enc_hc(enc_hc), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  hamming_tx_ctrl #(.CLKS_PER_BIT(4), .ENC_LAT(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_data(s_data2), .s_ready(s_ready2),
    .enc_wren(enc_wren2), .enc_data(enc_data2), .enc_hc(enc_hc2), .tx(tx2), .busy(busy2),
    .frame_done(frame_done2)
  );

  // Reference 12/8 Hamming code: data in non-power-of-two positions, even parity bits.
  function automatic logic [11:0] ham(input logic [7:0] d);
    logic [11:0] c;
    logic p;
    int j;
    c = '0;
    j = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if (pos != 1 && pos != 2 && pos != 4 && pos != 8) begin
        c[pos-1] = d[j];
        j++;
      end
    end
    for (int pb = 1; pb <= 8; pb = pb * 2) begin
      p = 1'b0;
      for (int pos = 1; pos <= 12; pos++)
        if ((pos & pb) != 0 && pos != pb) p = p ^ c[pos-1];
      c[pb-1] = p;
    end
    return c;
  endfunction

  // Line level expected k cycles after the accept edge.
  function automatic logic exp_tx(input int k, input int lat, input int cpb, input logic [11:0] cw);
    int idx;
    if (k < 2 + lat) return 1'b1;
    idx = (k - 2 - lat) / cpb;
    if (idx == 0) return 1'b0;
    if (idx <= 12) return cw[idx-1];
    return 1'b1;
  endfunction

  // Encoder with one cycle of latency for the default instance.
  always @(posedge clk) begin
    if (enc_wren) enc_hc <= fixed_en ? fixed_cw : ham(enc_data);
  end

  task automatic test_reset();
    s_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", tx); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
    checks++; if (enc_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b exp=0", enc_wren); end
    checks++; if (enc_data !== 8'h00) begin errors++; $display("FAIL rst_enc_data got=%h exp=00", enc_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", frame_done); end
    checks++; if (tx2 !== 1'b1 || s_ready2 !== 1'b1) begin
      errors++; $display("FAIL rst_dut2 tx=%b ready=%b exp=1/1", tx2, s_ready2);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || s_ready !== 1'b1 || enc_wren !== 1'b0 || frame_done !== 1'b0 ||
          tx2 !== 1'b1 || s_ready2 !== 1'b1) begin
        errors++;
        $display("FAIL idle c=%0d tx=%b ready=%b wren=%b done=%b tx2=%b ready2=%b exp=1/1/0/0/1/1",
                 c, tx, s_ready, enc_wren, frame_done, tx2, s_ready2);
      end
    end
    $display("reset idle: 100 cycles observed, errors so far=%0d", errors);
  endtask

  // One frame on the default instance; pulse_at>0 offers a stray byte while busy.
  task automatic test_frame(input logic [7:0] b, input logic [11:0] cw, input int pulse_at,
                            input string name);
    int e0 = errors;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL %s accept_ready got=%b exp=1", name, s_ready); end
    s_valid = 1'b1;
    s_data = b;
    @(posedge clk);
    for (int k = 1; k <= 247; k++) begin
      @(negedge clk);
      if (k == 1) s_valid = 1'b0;
      if (k == pulse_at) begin s_valid = 1'b1; s_data = ~b; end
      if (k == pulse_at + 1) s_valid = 1'b0;
      checks++; if (enc_wren !== (k == 1)) begin
        errors++; $display("FAIL %s wren k=%0d got=%b exp=%b", name, k, enc_wren, (k == 1));
      end
      if (k == 1) begin
        checks++; if (enc_data !== b) begin errors++; $display("FAIL %s enc_data got=%h exp=%h", name, enc_data, b); end
      end
      checks++; if (tx !== exp_tx(k, 1, 16, cw)) begin
        errors++; $display("FAIL %s tx k=%0d got=%b exp=%b", name, k, tx, exp_tx(k, 1, 16, cw));
      end
      checks++; if (frame_done !== (k == 226)) begin
        errors++; $display("FAIL %s done k=%0d got=%b exp=%b", name, k, frame_done, (k == 226));
      end
      checks++; if (s_ready !== (k >= 227) || busy !== (k < 227)) begin
        errors++; $display("FAIL %s ready k=%0d got=%b/%b exp=%b/%b", name, k, s_ready, busy, (k >= 227), (k < 227));
      end
    end
    $display("%s: byte=%h cw=%h frame errors=%0d", name, b, cw, errors - e0);
  endtask

  task automatic test_random_frames();
    logic [7:0] b;
    fixed_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      test_frame(b, ham(b), 0, "random");
    end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    int e0 = errors;
    b = 8'($urandom);
    enc_hc2 = 12'h000;
    @(negedge clk);
    checks++; if (s_ready2 !== 1'b1) begin errors++; $display("FAIL lat accept_ready got=%b exp=1", s_ready2); end
    s_valid2 = 1'b1;
    s_data2 = b;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) s_valid2 = 1'b0;
      // Only the value present in the third WAIT cycle may be captured.
      if (k == 2) enc_hc2 = 12'h123;
      if (k == 3) enc_hc2 = 12'h456;
      if (k == 4) enc_hc2 = 12'hFFF;
      checks++; if (enc_wren2 !== (k == 1)) begin
        errors++; $display("FAIL lat wren k=%0d got=%b exp=%b", k, enc_wren2, (k == 1));
      end
      if (k == 1) begin
        checks++; if (enc_data2 !== b) begin errors++; $display("FAIL lat enc_data got=%h exp=%h", enc_data2, b); end
      end
      checks++; if (tx2 !== exp_tx(k, 3, 4, 12'hFFF)) begin
        errors++; $display("FAIL lat tx k=%0d got=%b exp=%b", k, tx2, exp_tx(k, 3, 4, 12'hFFF));
      end
      checks++; if (frame_done2 !== (k == 60)) begin
        errors++; $display("FAIL lat done k=%0d got=%b exp=%b", k, frame_done2, (k == 60));
      end
      checks++; if (s_ready2 !== (k >= 61) || busy2 !== (k < 61)) begin
        errors++; $display("FAIL lat ready k=%0d got=%b/%b exp=%b/%b", k, s_ready2, busy2, (k >= 61), (k < 61));
      end
    end
    $display("latency: byte=%h cw=fff frame errors=%0d", b, errors - e0);
  endtask

  task automatic test_back_to_back();
    int wren_t[$];
    logic [7:0] wren_d[$];
    logic [7:0] bytes [3];
    int idx = 0;
    bit pend;
    logic wren_prev = 1'b0;
    logic prev_tx;
    int e0 = errors;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03;
    fixed_en = 1'b0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b accept_ready got=%b exp=1", s_ready); end
    s_valid = 1'b1;
    s_data = bytes[0];
    pend = 1'b1;
    prev_tx = tx;
    for (int n = 0; n < 720; n++) begin
      @(negedge clk);
      if (enc_wren) begin
        wren_t.push_back(n);
        wren_d.push_back(enc_data);
        checks++; if (wren_prev) begin errors++; $display("FAIL b2b wren_double n=%0d got=1 exp=0", n); end
      end
      wren_prev = enc_wren;
      if (wren_t.size() > 0) begin
        checks++; if (s_ready !== (n - wren_t[$] >= 226)) begin
          errors++; $display("FAIL b2b ready n=%0d got=%b exp=%b", n, s_ready, (n - wren_t[$] >= 226));
        end
        if (n == wren_t[$] + 2) begin
          checks++; if (!(prev_tx === 1'b1 && tx === 1'b0)) begin
            errors++; $display("FAIL b2b start n=%0d got=%b%b exp=10", n, prev_tx, tx);
          end
        end
      end
      prev_tx = tx;
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 3) s_data = bytes[idx];
        else s_valid = 1'b0;
      end
      if (s_valid && s_ready) pend = 1'b1;
    end
    checks++; if (wren_t.size() != 3) begin
      errors++; $display("FAIL b2b count got=%0d exp=3", wren_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (wren_d[i] !== bytes[i]) begin
          errors++; $display("FAIL b2b data%0d got=%h exp=%h", i, wren_d[i], bytes[i]);
        end
        if (i > 0) begin
          checks++; if (wren_t[i] - wren_t[i-1] != 227) begin
            errors++; $display("FAIL b2b spacing%0d got=%0d exp=227", i, wren_t[i] - wren_t[i-1]);
          end
        end
      end
    end
    $display("back_to_back: pulses=%0d errors=%0d", wren_t.size(), errors - e0);
  endtask

  task automatic test_reset_mid_frame();
    int e0 = errors;
    fixed_en = 1'b1;
    fixed_cw = 12'hFDF;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = 8'($urandom);
    @(posedge clk);
    for (int k = 1; k <= 105; k++) begin
      @(negedge clk);
      if (k == 1) s_valid = 1'b0;
    end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid bit5 got=%b exp=0", tx); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL mid async tx=%b ready=%b busy=%b done=%b exp=1/1/0/0", tx, s_ready, busy, frame_done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (tx !== 1'b1 || frame_done !== 1'b0) begin
        errors++; $display("FAIL mid held tx=%b done=%b exp=1/0", tx, frame_done);
      end
    end
    rst_n = 1'b1;
    fixed_en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (tx !== 1'b1 || s_ready !== 1'b1 || enc_wren !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL mid after tx=%b ready=%b wren=%b done=%b exp=1/1/0/0", tx, s_ready, enc_wren, frame_done);
      end
    end
    $display("reset_mid_frame: errors=%0d", errors - e0);
  endtask

  initial begin
    logic [7:0] b;
    test_reset();
    fixed_en = 1'b1;
    fixed_cw = 12'hA5C;
    test_frame(8'h3C, 12'hA5C, 0, "single");
    test_random_frames();
    b = 8'($urandom);
    test_frame(b, ham(b), 60, "backpressure");
    test_latency();
    test_back_to_back();
    test_reset_mid_frame();
    b = 8'($urandom);
    test_frame(b, ham(b), 0, "after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_tx_ctrl.md
# hamming_tx_ctrl

Transmit-side sequencer for the 12/8 Hamming encoder. It accepts bytes over a valid/ready handshake and pulses the encoder's write enable. It captures the 12-bit codeword once the encoder latency has elapsed. It then serializes the codeword onto a single asynchronous line framed as start bit, 12 code bits LSB first, and stop bit. It sits between the byte source and the serial link, owning the encoder's `wren`/`data` inputs and consuming its `hc_out`.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are ≥ 2.
- `ENC_LAT`, default 1: cycles from the encoder `wren` cycle until `hc_out` is valid. Legal values are ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  input byte valid.
- `s_data`  in  8  input byte.
- `s_ready`  out  1  controller can accept a byte.
- `enc_wren`  out  1  one-cycle write pulse to the encoder.
- `enc_data`  out  8  byte presented to the encoder.
- `enc_hc`  in  12  codeword from the encoder. Valid `ENC_LAT` cycles after the `enc_wren` cycle, held until the next `enc_wren`.
- `tx`  out  1  serial output, idle high.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when the stop bit completes.

## Operation
- FSM states: IDLE, WREN, WAIT, START, DATA, STOP.
- IDLE:
  - `s_ready`=1, `tx`=1.
  - On `s_valid&&s_ready`: latch `s_data` into `data_q` and go to WREN.
- WREN (1 cycle): `enc_wren`=1, `enc_data`=`data_q`. Go to WAIT.
- WAIT (`ENC_LAT` cycles):
  - Latency counter counts 0..`ENC_LAT`-1.
  - On the last cycle: `shift_q` <= `enc_hc`, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - `tx`=`shift_q[0]`.
  - Baud counter counts 0..`CLKS_PER_BIT`-1. At wrap: `shift_q` shifts right one bit and the bit index increments (4-bit, 0..11).
  - After bit 11 wraps, go to STOP.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - On the last cycle: `frame_done`=1, go to IDLE.
- Register widths: baud counter `$clog2(CLKS_PER_BIT)` bits; latency counter `$clog2(ENC_LAT+1)` bits. Both clear on every state entry.
- `enc_data` always drives `data_q`. It only has meaning during WREN.
- No new byte is accepted until the frame completes: `s_ready`=0 outside IDLE. `s_valid` held during a frame is accepted in the first IDLE cycle.
- `tx` is driven from a register, so it is glitch-free.
- Reset mid-frame:
  - All state returns to IDLE immediately and asynchronously.
  - `tx` goes to 1 with no partial stop bit and no `frame_done`.
  - The aborted byte is dropped.

## Timing
- Reset values: `s_ready`=1, `enc_wren`=0, `enc_data`=0, `tx`=1, `busy`=0, `frame_done`=0. Internal `data_q`, `shift_q` and counters are 0.
- Accept edge E0 (`s_valid&&s_ready` sampled high):
  - cycle E0+1: `enc_wren`=1.
  - cycles E0+2 .. E0+1+`ENC_LAT`: WAIT.
  - first START cycle: E0+2+`ENC_LAT`.
- Frame length is 14·`CLKS_PER_BIT` cycles: start + 12 data + stop.
- With defaults:
  - `tx` falls in cycle E0+3.
  - `frame_done` is high in cycle E0+226.
  - `s_ready` is high in cycle E0+227.
  - Next accept is possible at edge E0+227.
- Back-to-back bytes with `s_valid` held: consecutive start bits are 227 cycles apart with defaults. Generally the spacing is 3+`ENC_LAT`+14·`CLKS_PER_BIT`−2+… = 1+`ENC_LAT`+14·`CLKS_PER_BIT`+1 cycles.
- `enc_wren` is never high for more than one consecutive cycle and never high outside WREN.
- `busy` equals `!s_ready` in every cycle.

## Test plan
- **Reset idle:** hold `rst_n`=0, then release with `s_valid`=0 for 100 cycles -> `tx`=1, `s_ready`=1, `enc_wren`=0, `frame_done`=0 throughout.
- **Single frame:** defaults; bench encoder model returns `enc_hc`=12'hA5C one cycle after `enc_wren`; send byte 0x3C -> `enc_data`=0x3C during the `enc_wren` pulse. `tx` (16 cycles per bit) = 0, then bits 0,0,1,1,1,0,1,0,0,1,0,1, then 1. `frame_done` is high in cycle E0+226.
- **Latency parameter:** `ENC_LAT`=3 and `CLKS_PER_BIT`=4, codeword 12'hFFF -> `tx` falls in cycle E0+5, stays high for 48 data cycles, and the frame lasts 56 cycles. The codeword is sampled only on the 3rd WAIT cycle; the bench changes `enc_hc` before that cycle and the change is ignored.
- **Back-to-back:** hold `s_valid`=1 for bytes 0x01, 0x02, 0x03 -> three `enc_wren` pulses 227 cycles apart, `s_ready`=0 between accepts, no lost or duplicated byte.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 5 -> `tx`=1 and `s_ready`=1 asynchronously, no `frame_done`. The next byte after release transmits a complete, correct frame.
- **Ready backpressure:** pulse `s_valid` for one cycle while `busy`=1 -> the byte is not accepted, and no extra `enc_wren` or frame is produced.
